// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with registered reads, optional
// hardwired zero register, write-to-read bypass and a sequenced re-initialisation engine.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              Clear,
  output logic              Busy,
  output logic              Done
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               init_we;
  logic [ADDR_W-1:0]  init_addr;
  logic               wr_acc;

  logic [DATA_W-1:0]  reg_q [NREGS];
  logic [DATA_W-1:0]  reg_d [NREGS];
  logic [ADDR_W-1:0]  rd_addr [2];
  logic [DATA_W-1:0]  rd_q [2];
  logic [DATA_W-1:0]  rd_d [2];

  // Value a register holds after reset or after the init sequence visits it.
  function automatic logic [DATA_W-1:0] init_val(input int unsigned i);
    if (ZERO_REG != 0 && i == 0) begin
      return '0;
    end
    return DATA_W'(i + 1);
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (Clear) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      ST_INIT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == CNT_W'(NREGS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy    = 1'b0;
    Done    = 1'b0;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        Busy    = 1'b1;
        init_we = 1'b1;
      end
      ST_DONE: Done = 1'b1;
      default: ;
    endcase
  end

  assign init_addr = idx_q[ADDR_W-1:0];
  // Writeback is locked out while the init engine owns the array.
  assign wr_acc = RegWrite && !Busy && !(ZERO_REG != 0 && WriteReg == '0);

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    assign reg_d[gi] = (init_we && init_addr == ADDR_W'(gi)) ? init_val(gi) :
                       (wr_acc && WriteReg == ADDR_W'(gi))   ? WriteData    :
                                                               reg_q[gi];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        reg_q[i] <= init_val(i);
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        reg_q[i] <= reg_d[i];
      end
    end
  end

  assign rd_addr[0] = ReadReg1;
  assign rd_addr[1] = ReadReg2;

  // Init writes never reach the bypass path because wr_acc is low while Busy.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign rd_d[gi] = (ZERO_REG != 0 && rd_addr[gi] == '0)            ? '0        :
                      (BYPASS != 0 && wr_acc && WriteReg == rd_addr[gi]) ? WriteData :
                                                                          reg_q[rd_addr[gi]];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_q[0] <= '0;
      rd_q[1] <= '0;
    end else begin
      rd_q[0] <= rd_d[0];
      rd_q[1] <= rd_d[1];
    end
  end

  assign ReadData1 = rd_q[0];
  assign ReadData2 = rd_q[1];

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: four configurations driven side by side, checked every cycle
// against a behavioural model plus hand-computed expectations from the test plan.
module tb_regfile_param;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset;

  // u0: default, u1: BYPASS=0, u2: ZERO_REG=1, u3: DATA_W=8 ADDR_W=3
  logic        we  [4];
  logic [2:0]  wa  [4];
  logic [31:0] wd  [4];
  logic [2:0]  ra1 [4];
  logic [2:0]  ra2 [4];
  logic        clr [4];
  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1, rd1_2, rd2_2;
  logic [7:0]  rd1_3, rd2_3;
  logic [3:0]  busy_v, done_v;

  regfile_param u0 (
    .Clk(Clk), .Reset(Reset), .RegWrite(we[0]), .WriteReg(wa[0][1:0]), .WriteData(wd[0]),
    .ReadReg1(ra1[0][1:0]), .ReadReg2(ra2[0][1:0]), .ReadData1(rd1_0), .ReadData2(rd2_0),
    .Clear(clr[0]), .Busy(busy_v[0]), .Done(done_v[0]));

  regfile_param #(.BYPASS(0)) u1 (
    .Clk(Clk), .Reset(Reset), .RegWrite(we[1]), .WriteReg(wa[1][1:0]), .WriteData(wd[1]),
    .ReadReg1(ra1[1][1:0]), .ReadReg2(ra2[1][1:0]), .ReadData1(rd1_1), .ReadData2(rd2_1),
    .Clear(clr[1]), .Busy(busy_v[1]), .Done(done_v[1]));

  regfile_param #(.ZERO_REG(1)) u2 (
    .Clk(Clk), .Reset(Reset), .RegWrite(we[2]), .WriteReg(wa[2][1:0]), .WriteData(wd[2]),
    .ReadReg1(ra1[2][1:0]), .ReadReg2(ra2[2][1:0]), .ReadData1(rd1_2), .ReadData2(rd2_2),
    .Clear(clr[2]), .Busy(busy_v[2]), .Done(done_v[2]));

  regfile_param #(.DATA_W(8), .ADDR_W(3)) u3 (
    .Clk(Clk), .Reset(Reset), .RegWrite(we[3]), .WriteReg(wa[3]), .WriteData(wd[3][7:0]),
    .ReadReg1(ra1[3]), .ReadReg2(ra2[3]), .ReadData1(rd1_3), .ReadData2(rd2_3),
    .Clear(clr[3]), .Busy(busy_v[3]), .Done(done_v[3]));

  int npass  = 0;
  int ntotal = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [31:0] rd1_of(input int k);
    case (k)
      0: return rd1_0;
      1: return rd1_1;
      2: return rd1_2;
      default: return {24'h0, rd1_3};
    endcase
  endfunction

  function automatic logic [31:0] rd2_of(input int k);
    case (k)
      0: return rd2_0;
      1: return rd2_1;
      2: return rd2_2;
      default: return {24'h0, rd2_3};
    endcase
  endfunction

  // Configuration of each instance, as the model sees it.
  function automatic int nregs(input int k);  return (k == 3) ? 8 : 4; endfunction
  function automatic bit cfg_zr(input int k); return k == 2; endfunction
  function automatic bit cfg_bp(input int k); return k != 1; endfunction
  function automatic logic [31:0] dmask(input int k);
    return (k == 3) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [2:0] amask(input int k); return 3'(nregs(k) - 1); endfunction
  function automatic logic [31:0] rval(input int k, input int i);
    if (cfg_zr(k) && i == 0) return 32'h0;
    return 32'(i + 1) & dmask(k);
  endfunction

  // Model: register contents, expected read outputs and position in the clear sequence
  // (-1 idle, 0..N-1 = init step visiting that register, N = done cycle).
  logic [31:0] m_r [4][8];
  logic [31:0] m_rd1 [4];
  logic [31:0] m_rd2 [4];
  int          m_phase [4];

  function automatic bit in_init(input int k);
    return m_phase[k] >= 0 && m_phase[k] < nregs(k);
  endfunction

  function automatic bit host_write(input int k);
    return we[k] && !in_init(k) && !(cfg_zr(k) && (wa[k] & amask(k)) == 3'd0);
  endfunction

  function automatic logic [31:0] mread(input int k, input logic [2:0] a);
    logic [2:0] aa;
    aa = a & amask(k);
    if (cfg_zr(k) && aa == 3'd0) return 32'h0;
    if (cfg_bp(k) && host_write(k) && (wa[k] & amask(k)) == aa) return wd[k] & dmask(k);
    return m_r[k][aa];
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 8; i++) m_r[k][i] <= rval(k, i);
        m_rd1[k]   <= 32'h0;
        m_rd2[k]   <= 32'h0;
        m_phase[k] <= -1;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        m_rd1[k] <= mread(k, ra1[k]);
        m_rd2[k] <= mread(k, ra2[k]);
        if (in_init(k)) m_r[k][m_phase[k]] <= rval(k, m_phase[k]);
        else if (host_write(k)) m_r[k][wa[k] & amask(k)] <= wd[k] & dmask(k);
        if (m_phase[k] == -1) begin
          if (clr[k]) m_phase[k] <= 0;
        end else if (m_phase[k] == nregs(k)) begin
          m_phase[k] <= -1;
        end else begin
          m_phase[k] <= m_phase[k] + 1;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("cyc u%0d rd1", k), rd1_of(k), m_rd1[k]);
        check($sformatf("cyc u%0d rd2", k), rd2_of(k), m_rd2[k]);
        check($sformatf("cyc u%0d busy", k), {31'h0, busy_v[k]}, {31'h0, in_init(k)});
        check($sformatf("cyc u%0d done", k), {31'h0, done_v[k]}, {31'h0, m_phase[k] == nregs(k)});
      end
    end
  end

  task automatic idle_all();
    for (int k = 0; k < 4; k++) begin
      we[k] = 1'b0; wa[k] = 3'd0; wd[k] = 32'h0;
      ra1[k] = 3'd0; ra2[k] = 3'd0; clr[k] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic read_chk(input int k, input int a, input logic [31:0] exp, input string tag);
    ra1[k] = 3'(a);
    ra2[k] = 3'(a);
    step();
    check($sformatf("%s u%0d rd1 r%0d", tag, k, a), rd1_of(k), exp);
    check($sformatf("%s u%0d rd2 r%0d", tag, k, a), rd2_of(k), exp);
  endtask

  // Pulse or hold Clear and count Busy/Done samples over a fixed window.
  task automatic run_clear(input int k, input int hold, input int window,
                           output int nb, output int nd);
    nb = 0;
    nd = 0;
    clr[k] = 1'b1;
    for (int s = 0; s < window; s++) begin
      step();
      if (busy_v[k]) nb++;
      if (done_v[k]) nd++;
      if (s == hold - 1) clr[k] = 1'b0;
      if (k == 0 && s == 0) begin we[0] = 1'b1; wa[0] = 3'd1; wd[0] = 32'h0000_AAAA; end
      if (k == 0 && s == 3) we[0] = 1'b0;
    end
  endtask

  int nb, nd;

  initial begin
    idle_all();
    Reset = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    check("reset rd1", rd1_of(0), 32'h0);
    check("reset busy", {31'h0, busy_v[0]}, 32'h0);
    Reset = 1'b1;

    for (int a = 0; a < 4; a++) read_chk(0, a, 32'(a + 1), "rstval");
    check("idle busy", {31'h0, busy_v[0]}, 32'h0);
    check("idle done", {31'h0, done_v[0]}, 32'h0);

    for (int k = 0; k < 2; k++) begin
      we[k] = 1'b1; wa[k] = 3'd2; wd[k] = 32'hDEAD_BEEF; ra1[k] = 3'd2; ra2[k] = 3'd2;
    end
    step();
    check("bypass u0 rd1", rd1_of(0), 32'hDEAD_BEEF);
    check("bypass u0 rd2", rd2_of(0), 32'hDEAD_BEEF);
    check("nobypass u1 rd1", rd1_of(1), 32'h3);
    check("nobypass u1 rd2", rd2_of(1), 32'h3);
    we[0] = 1'b0; we[1] = 1'b0;
    step();
    check("nobypass u1 later", rd1_of(1), 32'hDEAD_BEEF);
    idle_all();

    we[2] = 1'b1; wa[2] = 3'd0; wd[2] = 32'h55;
    read_chk(2, 0, 32'h0, "zero wr");
    we[2] = 1'b0;
    read_chk(2, 0, 32'h0, "zero rd");
    we[2] = 1'b1; wa[2] = 3'd1; wd[2] = 32'h7;
    read_chk(2, 1, 32'h7, "zr r1 byp");
    we[2] = 1'b0;
    read_chk(2, 1, 32'h7, "zr r1");
    idle_all();

    for (int a = 0; a < 4; a++) begin
      we[0] = 1'b1; wa[0] = 3'(a); wd[0] = 32'h9;
      step();
    end
    we[0] = 1'b0;
    read_chk(0, 3, 32'h9, "pre clr");
    run_clear(0, 1, 8, nb, nd);
    check("clr busy cycles", 32'(nb), 32'd4);
    check("clr done cycles", 32'(nd), 32'd1);
    for (int a = 0; a < 4; a++) read_chk(0, a, 32'(a + 1), "post clr");
    idle_all();

    we[0] = 1'b1; wa[0] = 3'd3; wd[0] = 32'h77;
    step();
    we[0] = 1'b0;
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    step();
    step();
    Reset = 1'b0;
    #1;
    check("abort busy", {31'h0, busy_v[0]}, 32'h0);
    check("abort done", {31'h0, done_v[0]}, 32'h0);
    check("abort rd1", rd1_of(0), 32'h0);
    check("abort rd2", rd2_of(0), 32'h0);
    #2;
    Reset = 1'b1;
    for (int a = 0; a < 4; a++) read_chk(0, a, 32'(a + 1), "post abort");
    read_chk(1, 2, 32'h3, "post abort");
    run_clear(0, 1, 8, nb, nd);
    check("reclr busy cycles", 32'(nb), 32'd4);
    check("reclr done cycles", 32'(nd), 32'd1);
    idle_all();

    for (int a = 0; a < 8; a++) read_chk(3, a, 32'(a + 1), "w8 rstval");
    we[3] = 1'b1; wa[3] = 3'd5; wd[3] = 32'h1AB;
    read_chk(3, 5, 32'hAB, "w8 trunc");
    we[3] = 1'b0;
    run_clear(3, 12, 25, nb, nd);
    check("held busy cycles", 32'(nb), 32'd16);
    check("held done cycles", 32'(nd), 32'd2);
    for (int a = 0; a < 8; a++) read_chk(3, a, 32'(a + 1), "w8 post clr");

    step();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
